cam_capture_window: RTL and testbench

- Single-clock capture front end for the OV7670 path.
- Oversamples raw camera pins (pixel clock, VSYNC, HREF, D[7:0]) in the system clock domain and assembles byte pairs into RGB565 pixels.
- Tracks x/y position and emits write strobes, a window address and pixel data for the 256x256 frame buffer.
- Sits between the camera pins and the buffer write port; replaces direct capture on the camera pixel clock.

---
 rtl/cam_capture_pkg.sv | 36 +++
 rtl/cam_sync_edge.sv | 34 +++
 rtl/cam_capture_window.sv | 161 ++++++++++++++++
 tb/tb_cam_capture_window.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_capture_pkg.sv
// cam_capture_pkg: shared types and luma coefficients for the camera capture window. Rev 1.0
// Macro GRAYSCALE_EN in the top selects whether gray565() is used on the write path.
`default_nettype none

package cam_capture_pkg;

  typedef enum logic [1:0] {
    WAIT_VS    = 2'd0,
    WAIT_START = 2'd1,
    ACTIVE     = 2'd2
  } cap_state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam logic [7:0] GRAY_R = 8'd77;
  localparam logic [7:0] GRAY_G = 8'd150;
  localparam logic [7:0] GRAY_B = 8'd29;

  // Luma from zero-padded 8-bit channels, replicated back into RGB565 lanes.
  function automatic logic [15:0] gray565(input rgb565_t p);
    logic [17:0] acc;
    logic [7:0]  g;
    acc = 18'({p.r, 3'b000}) * 18'(GRAY_R)
        + 18'({p.g, 2'b00})  * 18'(GRAY_G)
        + 18'({p.b, 3'b000}) * 18'(GRAY_B);
    g = 8'(acc >> 8);
    return {g[7:3], g[7:2], g[7:3]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/cam_sync_edge.sv
// cam_sync_edge: 2-FF synchronizer with registered rise/fall detect; level is aligned to the edges. Rev 1.0
`default_nettype none

module cam_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      level <= s2;
      rise  <= s2 & ~level;
      fall  <= ~s2 & level;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cam_capture_window.sv
// cam_capture_window: oversampled OV7670 capture, RGB565 pairing and 256x256 window write port. Rev 1.0
// Define GRAYSCALE_EN to store luma-only pixels through one extra pipeline register.
`default_nettype none

module cam_capture_window #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int WIN_W    = 256,
  parameter int WIN_H    = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cam_pclk,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        capture_en,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_done,
  output logic [8:0]  line_cnt,
  output logic        err_sync
);

  import cam_capture_pkg::*;

  localparam int XW = $clog2(((H_ACTIVE > WIN_W) ? H_ACTIVE : WIN_W) + 1);
  localparam logic [XW-1:0] X_LIM  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_WIN  = XW'(WIN_W);
  localparam logic [8:0]    Y_LAST = 9'(V_ACTIVE - 1);
  localparam logic [8:0]    Y_WIN  = 9'(WIN_H);

  logic pc_level, pc_rise, pc_fall;
  logic vs_level, vs_rise, vs_fall;
  logic hr_level, hr_rise, hr_fall;

  cam_sync_edge u_sync_pclk (
    .clk(clk), .rst_n(rst_n), .din(cam_pclk),
    .level(pc_level), .rise(pc_rise), .fall(pc_fall)
  );
  cam_sync_edge u_sync_vsync (
    .clk(clk), .rst_n(rst_n), .din(cam_vsync),
    .level(vs_level), .rise(vs_rise), .fall(vs_fall)
  );
  cam_sync_edge u_sync_href (
    .clk(clk), .rst_n(rst_n), .din(cam_href),
    .level(hr_level), .rise(hr_rise), .fall(hr_fall)
  );

  // Data takes the same three register hops as the control edges.
  logic [7:0] d1, d2, d3;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d1 <= 8'd0;
      d2 <= 8'd0;
      d3 <= 8'd0;
    end else begin
      d1 <= cam_data;
      d2 <= d1;
      d3 <= d2;
    end
  end

  cap_state_t     state;
  logic           cap_lat;
  logic [XW-1:0]  x;
  logic [8:0]     y;
  logic           phase;
  logic [7:0]     hi;
  logic           pix_en;
  logic [15:0]    pix_addr;
  logic [15:0]    pix_data;
  logic [15:0]    x_ext;

  assign x_ext    = 16'(x);
  assign line_cnt = y;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= WAIT_VS;
      cap_lat    <= 1'b0;
      x          <= '0;
      y          <= 9'd0;
      phase      <= 1'b0;
      hi         <= 8'd0;
      pix_en     <= 1'b0;
      pix_addr   <= 16'd0;
      pix_data   <= 16'd0;
      frame_done <= 1'b0;
      err_sync   <= 1'b0;
    end else begin
      pix_en     <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        WAIT_VS: begin
          if (vs_rise) state <= WAIT_START;
        end
        WAIT_START: begin
          if (vs_fall) begin
            cap_lat <= capture_en;
            x       <= '0;
            y       <= 9'd0;
            phase   <= 1'b0;
            state   <= ACTIVE;
          end
        end
        ACTIVE: begin
          // Frame end outranks a coincident line end.
          if (vs_rise) begin
            frame_done <= 1'b1;
            state      <= WAIT_START;
          end else if (hr_fall) begin
            x     <= '0;
            phase <= 1'b0;
            if (y != Y_LAST) y <= y + 9'd1;
            if (phase) err_sync <= 1'b1;
          end else if (hr_level && pc_rise) begin
            if (x >= X_LIM) begin
              err_sync <= 1'b1;
            end else if (!phase) begin
              hi    <= d3;
              phase <= 1'b1;
            end else begin
              pix_en   <= cap_lat && (x < X_WIN) && (y < Y_WIN);
              pix_addr <= {y[7:0], x_ext[7:0]};
              pix_data <= {hi, d3};
              x        <= x + 1'b1;
              phase    <= 1'b0;
            end
          end
        end
        default: state <= WAIT_VS;
      endcase
    end
  end

`ifdef GRAYSCALE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= 16'd0;
      wr_data <= 16'd0;
    end else begin
      wr_en   <= pix_en;
      wr_addr <= pix_addr;
      wr_data <= gray565(pix_data);
    end
  end
`else
  assign wr_en   = pix_en;
  assign wr_addr = pix_addr;
  assign wr_data = pix_data;
`endif

  logic unused_sigs;
  assign unused_sigs = &{1'b0, pc_level, pc_fall, vs_level, hr_rise, x_ext[15:8]};

endmodule

`default_nettype wire

// File: tb/tb_cam_capture_window.sv
// tb_cam_capture_window: directed frames with random pixels checked against a frame-level write model.
`default_nettype none

module tb_cam_capture_window;

  localparam int H  = 24;
  localparam int V  = 20;
  localparam int WW = 16;
  localparam int WH = 16;
`ifdef GRAYSCALE_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif
  localparam int FD_LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cam_pclk = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'd0;
  logic        capture_en = 1'b1;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        frame_done;
  logic [8:0]  line_cnt;
  logic        err_sync;

  cam_capture_window #(.H_ACTIVE(H), .V_ACTIVE(V), .WIN_W(WW), .WIN_H(WH)) dut (
    .clk(clk), .rst_n(rst_n), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .capture_en(capture_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .line_cnt(line_cnt), .err_sync(err_sync)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] obs_q[$];
  int          obs_cyc[$];
  int          fd_cnt = 0;
  int          fd_cyc = 0;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      obs_q.push_back({wr_addr, wr_data});
      obs_cyc.push_back(cyc);
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  int checks = 0;
  int errors = 0;
  int last_rise = 0;
  bit m_err = 1'b0;
  int nb_arr [0:31];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_data(input logic [15:0] p);
`ifdef GRAYSCALE_EN
    int r8, g8, b8, g;
    logic [7:0] gl;
    r8 = int'(p[15:11]) * 8;
    g8 = int'(p[10:5]) * 4;
    b8 = int'(p[4:0]) * 8;
    g  = (r8 * 77 + g8 * 150 + b8 * 29) / 256;
    gl = 8'(g);
    return {gl[7:3], gl[7:2], gl[7:3]};
`else
    return p;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // pclk = clk/3: two cycles low with data presented, one cycle high.
  task automatic send_byte(input logic [7:0] b);
    cam_data = b;
    tick(2);
    cam_pclk  = 1'b1;
    last_rise = cyc;
    tick(1);
    cam_pclk = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_line_cnt"}, 32'(line_cnt), 32'd0);
    chk({tag, "_err_sync"}, 32'(err_sync), 32'd0);
  endtask

  task automatic do_reset();
    cam_vsync = 1'b0;
    rst_n = 1'b0;
    tick(3);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    m_err = 1'b0;
    tick(4);
    cam_vsync = 1'b1;
    tick(10);
  endtask

  task automatic run_frame(input int nlines, input bit counting, input int rst_line, input int drop_line);
    logic [15:0] px [0:31][0:31];
    int          ey [0:31];
    bit          ee [0:31];
    logic [31:0] exp_q[$];
    logic [15:0] pv;
    logic [7:0]  b;
    int          y, npx, obs_base, fd_base, first_rise, vs_cyc, nobs;
    bit          cap, act;

    for (int l = 0; l < nlines; l++)
      for (int i = 0; i < 32; i++)
        px[l][i] = counting ? 16'(l * H + i) : 16'($urandom);

    // Reference: each full pixel below H lands at {y, x} if the frame was armed and inside the window.
    cap = capture_en;
    act = 1'b1;
    y   = 0;
    for (int l = 0; l < nlines; l++) begin
      if (l == rst_line) begin
        act   = 1'b0;
        y     = 0;
        m_err = 1'b0;
      end
      if (act) begin
        npx = nb_arr[l] / 2;
        if (npx > H) npx = H;
        for (int i = 0; i < npx; i++)
          if (cap && i < WW && y < WH)
            exp_q.push_back({8'(y), 8'(i), exp_data(px[l][i])});
        if (nb_arr[l] > 2 * H || (nb_arr[l] % 2) == 1) m_err = 1'b1;
        if (y < V - 1) y = y + 1;
      end
      ey[l] = y;
      ee[l] = m_err;
    end

    obs_base   = obs_q.size();
    fd_base    = fd_cnt;
    first_rise = 0;
    cam_vsync  = 1'b0;
    tick(8);
    for (int l = 0; l < nlines; l++) begin
      if (l == drop_line) capture_en = 1'b0;
      cam_href = 1'b1;
      tick(2);
      for (int k = 0; k < nb_arr[l]; k++) begin
        if (l == rst_line && k == 1) begin
          rst_n = 1'b0;
          tick(2);
          chk_reset_outputs("midrst");
          tick(2);
          rst_n = 1'b1;
        end
        pv = px[l][k / 2];
        b  = k[0] ? pv[7:0] : pv[15:8];
        send_byte(b);
        if (l == 0 && k == 1) first_rise = last_rise;
      end
      tick(1);
      cam_href = 1'b0;
      tick(8);
      chk("line_cnt", 32'(line_cnt), 32'(ey[l]));
      chk("err_sync", 32'(err_sync), 32'(ee[l]));
    end
    cam_vsync = 1'b1;
    vs_cyc = cyc;
    tick(12);

    nobs = obs_q.size() - obs_base;
    chk("wr_count", 32'(nobs), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < nobs; i++)
      chk("wr_addr_data", obs_q[obs_base + i], exp_q[i]);
    if (exp_q.size() > 0 && nobs > 0)
      chk("wr_latency", 32'(obs_cyc[obs_base] - first_rise), 32'(LAT));
    chk("frame_done_cnt", 32'(fd_cnt - fd_base), 32'(act));
    if (act)
      chk("frame_done_latency", 32'(fd_cyc - vs_cyc), 32'(FD_LAT));
  endtask

  initial begin
    for (int l = 0; l < 32; l++) nb_arr[l] = 2 * H;
    tick(4);
    chk_reset_outputs("init");
    rst_n = 1'b1;
    tick(4);
    cam_vsync = 1'b1;
    tick(10);

    run_frame(V, 1'b1, -1, -1);            // counting pixels, full window
    run_frame(V + 2, 1'b0, -1, -1);        // y saturation at V-1

    nb_arr[1] = 2 * H - 1;                 // odd byte count line
    run_frame(5, 1'b0, -1, -1);
    nb_arr[1] = 2 * H;

    do_reset();
    nb_arr[1] = 2 * (H + 6);               // overrun line
    run_frame(4, 1'b0, -1, -1);
    nb_arr[1] = 2 * H;

    do_reset();
    run_frame(6, 1'b0, -1, 2);             // capture_en dropped mid-frame
    run_frame(4, 1'b0, -1, -1);            // frozen frame

    capture_en = 1'b1;
    run_frame(6, 1'b0, 3, -1);             // reset mid-line, released mid-frame
    run_frame(4, 1'b0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
